// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and constants for the mux select scanner: FSM state
// encoding, channel count and the channel-to-select mapping.
package mux_sel_scanner_pkg;

    localparam int NCH   = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2
    } state_t;

    // {s1, s2} for each data input of the 4:1 mux
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_CH3 = 2'b11;

    function automatic logic [1:0] sel_of(input logic [IDX_W-1:0] idx);
        logic [1:0] sel;
        case (idx)
            2'd0:    sel = SEL_CH0;
            2'd1:    sel = SEL_CH1;
            2'd2:    sel = SEL_CH2;
            default: sel = SEL_CH3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_sel_scanner_rr_pick.sv
// Combinational round-robin picker: the winner is the first set request
// bit found searching upward from (last + 1), wrapping around.
module rr_pick
    import mux_sel_scanner_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// Mux select scanner: grants one of four requesters round-robin, drives the
// 4:1 mux selects for a programmable dwell (or until ack), then reports
// release with a one-cycle done pulse. All outputs come straight from flops.
module mux_sel_scanner
    import mux_sel_scanner_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    input  logic [CNT_W-1:0] dwell,
    input  logic             ack,
    output logic             s1,
    output logic             s2,
    output logic [NCH-1:0]   gnt,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] last_reg;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [NCH-1:0]   pick_onehot;
    logic             grant_now;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // One-hot form of the winner and the decision to issue a new grant
    always_comb begin
        pick_onehot = NCH'(1) << pick_idx;
        grant_now   = en && pick_valid && (state_reg == IDLE || state_reg == REL);
    end

    // Scanner FSM with registered outputs; selects persist through REL/IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= IDX_W'(NCH - 1);
            s1        <= 1'b0;
            s2        <= 1'b0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (grant_now) begin
                state_reg  <= HOLD;
                cnt_reg    <= dwell;
                last_reg   <= pick_idx;
                gnt        <= pick_onehot;
                {s1, s2}   <= sel_of(pick_idx);
                busy       <= 1'b1;
            end else begin
                case (state_reg)
                    HOLD: begin
                        // Release on whichever comes first; both together is one release
                        if (ack || cnt_reg == '0) begin
                            state_reg <= REL;
                            gnt       <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    REL:     state_reg <= IDLE;
                    IDLE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: each scenario queues the expected
// per-edge output word {gnt, s1, s2, busy, done}, then steps the clock and
// compares what the DUT shows one time unit after each rising edge.
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       ack;
    logic       s1;
    logic       s2;
    logic [3:0] gnt;
    logic       busy;
    logic       done;

    logic [7:0] sb[$];
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    int         vectors;
    int         miscompares;

    mux_sel_scanner #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .dwell (dwell),
        .ack   (ack),
        .s1    (s1),
        .s2    (s2),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected words: HOLD on ch, REL after ch, IDLE with ch's select, reset
    function automatic logic [7:0] e_hold(input int ch);
        logic [1:0] c;
        logic [3:0] one;
        c   = ch[1:0];
        one = 4'b0001;
        return {one << c, c, 1'b1, 1'b0};
    endfunction

    function automatic logic [7:0] e_rel(input int ch);
        logic [1:0] c;
        c = ch[1:0];
        return {4'b0000, c, 1'b0, 1'b1};
    endfunction

    function automatic logic [7:0] e_idle(input int ch);
        logic [1:0] c;
        c = ch[1:0];
        return {4'b0000, c, 1'b0, 1'b0};
    endfunction

    function automatic logic [7:0] e_zero();
        return 8'h00;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 4'b0001; dwell = 4'd2; ack = 1'b0;
        sb.push_back(e_zero()); sb.push_back(e_zero());
        sb.push_back(e_hold(0)); sb.push_back(e_hold(0)); sb.push_back(e_hold(0));
        sb.push_back(e_rel(0)); sb.push_back(e_idle(0));
        for (int k = 0; k < 7; k++) begin
            if (k == 2) rst_n = 1'b1;
            if (k == 3) req = 4'b0000;
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_dwell2 cyc%0d got gnt,s1s2,busy,done=%b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        sb.push_back(e_zero());
        sb.push_back(e_hold(0)); sb.push_back(e_rel(0));
        sb.push_back(e_hold(1)); sb.push_back(e_rel(1));
        sb.push_back(e_hold(2)); sb.push_back(e_rel(2));
        sb.push_back(e_hold(3)); sb.push_back(e_rel(3));
        sb.push_back(e_hold(0)); sb.push_back(e_rel(0));
        sb.push_back(e_idle(0));
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:  rst_n = 1'b0;
                1:  begin rst_n = 1'b1; en = 1'b1; req = 4'b1111; dwell = 4'd0; end
                10: req = 4'b0000;
                default: ;
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL round_robin cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_ack_release();
        sb.push_back(e_hold(2)); sb.push_back(e_hold(2));
        sb.push_back(e_rel(2)); sb.push_back(e_idle(2)); sb.push_back(e_idle(2));
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin en = 1'b1; req = 4'b0100; dwell = 4'd7; end
                1: req = 4'b0000;
                2: ack = 1'b1;
                3: ack = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL ack_release cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_drop_req_en();
        sb.push_back(e_hold(1)); sb.push_back(e_hold(1));
        sb.push_back(e_hold(1)); sb.push_back(e_hold(1));
        sb.push_back(e_rel(1)); sb.push_back(e_idle(1));
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin en = 1'b1; req = 4'b0010; dwell = 4'd3; end
                1: begin en = 1'b0; req = 4'b0000; dwell = 4'd0; end
                5: en = 1'b1;
                default: ;
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL drop_req_en cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        sb.push_back(e_hold(3)); sb.push_back(e_hold(3));
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin en = 1'b1; req = 4'b1000; dwell = 4'd5; end
            if (k == 1) req = 4'b0000;
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_hold grant cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
        // Asynchronous clear, checked between clock edges
        sb.push_back(e_zero());
        rst_n = 1'b0;
        #1;
        exp_v = sb.pop_front();
        obs_v = {gnt, s1, s2, busy, done};
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset_mid_hold async got %b need %b", obs_v, exp_v);
        end
        sb.push_back(e_zero());
        sb.push_back(e_hold(3)); sb.push_back(e_rel(3)); sb.push_back(e_idle(3));
        for (int k = 2; k < 6; k++) begin
            case (k)
                3: begin rst_n = 1'b1; req = 4'b1000; dwell = 4'd0; end
                4: req = 4'b0000;
                default: ;
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_hold cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(e_idle(3));
        sb.push_back(e_hold(1)); sb.push_back(e_rel(1));
        sb.push_back(e_hold(0)); sb.push_back(e_rel(0));
        sb.push_back(e_idle(0)); sb.push_back(e_idle(0)); sb.push_back(e_idle(0));
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin en = 1'b0; req = 4'b1111; end
                1: begin en = 1'b1; req = 4'b0010; dwell = 4'd0; end
                2: req = 4'b0011;
                4: begin req = 4'b0000; ack = 1'b1; end
                7: ack = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            obs_v = {gnt, s1, s2, busy, done};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back_wrap cyc%0d got %b need %b", k, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_ack_release();
        test_drop_req_en();
        test_reset_mid_hold();
        test_back_to_back();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_sel_scanner.md
MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

Interface
REQ-001 Parameter CNT_W, default 4, width of the dwell counter and dwell input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  scanner enable; new grants issue only while high.
REQ-005 req  input  4  per-channel request, bit i = mux data input i (0=a, 1=b, 2=c, 3=d).
REQ-006 dwell  input  CNT_W  hold length minus one, sampled at grant.
REQ-007 ack  input  1  downstream consumer has sampled y; releases the current grant early.
REQ-008 s1  output  1  mux select MSB, registered.
REQ-009 s2  output  1  mux select LSB, registered.
REQ-010 gnt  output  4  one-hot granted channel, all-zero when idle, registered.
REQ-011 busy  output  1  high while a grant is held.
REQ-012 done  output  1  one-cycle pulse on the cycle after a grant is released.

Function
REQ-013 The select encoding SHALL be channel 0 -> s1=0,s2=0; 1 -> 0,1; 2 -> 1,0; 3 -> 1,1.
REQ-014 The FSM SHALL have states IDLE, HOLD, REL.
REQ-015 IDLE -> HOLD SHALL occur when en=1 and req!=0; otherwise IDLE is held.
REQ-016 Arbitration SHALL be round-robin: the winner is the first set req bit searching upward from (last+1) mod 4, wrapping.
REQ-017 On entering HOLD, gnt, s1/s2 and busy SHALL update on the same edge (one-cycle latency from the req/en sample); last SHALL load the winner index; cnt SHALL load dwell.
REQ-018 In HOLD, cnt SHALL decrement each cycle; HOLD -> REL SHALL occur when cnt==0 or ack=1, whichever is first.
REQ-019 dwell=0 SHALL yield exactly one HOLD cycle; dwell=D SHALL yield D+1 HOLD cycles absent ack.
REQ-020 Simultaneous ack and cnt==0 SHALL cause a single release, not two.
REQ-021 s1/s2 SHALL remain stable for the entire HOLD period, regardless of req changes.
REQ-022 A req bit dropping during HOLD SHALL NOT shorten the grant.
REQ-023 en dropping during HOLD SHALL NOT abort the grant; the grant completes and the FSM returns to IDLE.
REQ-024 In REL, gnt SHALL be 0, busy SHALL be 0, done SHALL be 1 for that cycle only; s1/s2 SHALL retain the last selection.
REQ-025 REL -> HOLD SHALL occur directly when en=1 and req!=0 (back-to-back grants, one REL gap cycle); otherwise REL -> IDLE.
REQ-026 ack SHALL be ignored in IDLE and REL.
REQ-027 cnt SHALL never wrap below zero.

Reset
REQ-028 While rst_n=0: state=IDLE, s1=0, s2=0, gnt=0, busy=0, done=0, cnt=0, last=3 (so channel 0 has first priority).
REQ-029 Reset asserted mid-HOLD SHALL clear all outputs immediately, without a done pulse.
REQ-030 The first grant after reset deassertion SHALL follow REQ-015..017, with no extra wait cycles.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, HOLD, REL), NCH=4 and the select-encoding constants.
REQ-032 Round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs req, last; outputs valid, idx).
REQ-033 All outputs SHALL be driven directly from flops, with no combinational path from req or ack to any output.

Verification
REQ-034 Reset release, en=1, req=4'b0001, dwell=2 -> next edge gnt=0001, s1s2=00, busy=1 for 3 cycles, then done pulse, then IDLE.
REQ-035 req=4'b1111 held, dwell=0, en=1 -> grants cycle 0,1,2,3,0 with s1s2 sequence 00,01,10,11,00, each separated by one REL cycle.
REQ-036 Grant ch2 with dwell=7, ack=1 on the 2nd HOLD cycle -> release after 2 HOLD cycles, single done pulse.
REQ-037 Grant ch1 with dwell=3, drop req and en on the 1st HOLD cycle -> s1s2=01 held for 4 cycles, done, then IDLE.
REQ-038 Assert rst_n=0 mid-HOLD on ch3 -> s1s2=00, gnt=0, busy=0 immediately, no done; the next grant with req=1000 selects ch3 from last=3 wrap, i.e. first priority is ch0.
REQ-039 last=1, req=4'b0011 -> winner ch0 (wrap-around), s1s2=00.
